// File: rtl/check_data_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : check_data_scanner
//  Description : Initiator side of the per-stage debug mux interface. Walks
//                check_addr across every pipeline segment (IF, ID, EX, MEM,
//                WB, HZD), captures the returned check_data into a snapshot
//                buffer, then streams the snapshot out one word at a time on
//                a valid/ready handshake toward the PDU debug output path.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SEG_NUM    number of segments scanned, addresses 0..SEG_NUM-1 (1..8)
//    SETTLE     extra cycles check_addr is held before capture (0..7)
//  Ports
//    clk        system clock, rising edge
//    rst        synchronous active-high reset
//    start      snapshot request, sampled every cycle
//    check_addr segment select to the debug mux
//    check_data selected debug word (combinational from check_addr)
//    out_data   snapshot word on offer
//    out_idx    segment index of out_data
//    out_valid  out_data/out_idx are valid
//    out_ready  consumer accepts the word this cycle
//    busy       scanner is in SCAN, SEND or FIN
//    done       one-cycle pulse after the last word transfers
//    drop       sticky flag: a start arrived while busy
// ============================================================================
module check_data_scanner #(
    parameter int SEG_NUM = 6,
    parameter int SETTLE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [2:0]  check_addr,
    input  logic [31:0] check_data,
    output logic [31:0] out_data,
    output logic [2:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        drop
);

    localparam logic [2:0] C_LAST   = 3'(SEG_NUM - 1);
    localparam logic [2:0] C_SETTLE = 3'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  seg_q,   seg_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [2:0]  rd_q,    rd_d;
    logic        drop_q,  drop_d;
    logic        capture_en;
    logic [31:0] snap_q [SEG_NUM];

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seg_q   <= 3'd0;
            cnt_q   <= 3'd0;
            rd_q    <= 3'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot buffer. Each entry is written only on its own capture edge,
    // so later changes on check_data never disturb words already held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEG_NUM; i++) begin
                snap_q[i] <= 32'd0;
            end
        end else if (capture_en) begin
            for (int i = 0; i < SEG_NUM; i++) begin
                if (seg_q == 3'(i)) begin
                    snap_q[i] <= check_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        capture_en = 1'b0;
        // Any start seen outside IDLE is lost; remember that until reset.
        drop_d     = drop_q | (start & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    seg_d   = 3'd0;
                    cnt_d   = 3'd0;
                end
            end

            ST_SCAN: begin
                // cnt counts the cycles check_addr has been held on seg;
                // capture once it has been stable for SETTLE extra cycles.
                if (cnt_q == C_SETTLE) begin
                    capture_en = 1'b1;
                    cnt_d      = 3'd0;
                    if (seg_q == C_LAST) begin
                        state_d = ST_SEND;
                        seg_d   = 3'd0;
                        rd_d    = 3'd0;
                    end else begin
                        seg_d = seg_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            ST_SEND: begin
                if (out_ready) begin
                    if (rd_q == C_LAST) begin
                        state_d = ST_FIN;
                        rd_d    = 3'd0;
                    end else begin
                        rd_d = rd_q + 3'd1;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded purely from registered state
    // ------------------------------------------------------------------
    always_comb begin
        check_addr = 3'd0;
        out_valid  = 1'b0;
        out_data   = 32'd0;
        out_idx    = 3'd0;
        if (state_q == ST_SCAN) begin
            check_addr = seg_q;
        end
        if (state_q == ST_SEND) begin
            out_valid = 1'b1;
            out_data  = snap_q[rd_q];
            out_idx   = rd_q;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIN);
    assign drop = drop_q;

endmodule
`default_nettype wire
